// File: rtl/modn_pkg.sv
// Shared types and default sizing for the mod-N count monitor.
package modn_pkg;

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } state_t;

  localparam int DEF_N      = 10;
  localparam int DEF_WIDTH  = 4;
  localparam int DEF_WRAP_W = 8;
  localparam int DEF_ERR_W  = 4;

endpackage

// File: rtl/modn_count_monitor_if.sv
// Bus between an upstream mod-N counter and its monitor: sampled count in, status out.
interface modn_count_monitor_if
  import modn_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int WRAP_W = DEF_WRAP_W,
  parameter int ERR_W  = DEF_ERR_W
) ();

  logic [WIDTH-1:0]  count;
  logic              clr_err;
  logic              wrap_tick;
  logic [WRAP_W-1:0] wrap_cnt;
  logic              restart;
  logic              err;
  logic [ERR_W-1:0]  err_cnt;
  logic              locked;

  modport master (
    output count, clr_err,
    input  wrap_tick, wrap_cnt, restart, err, err_cnt, locked
  );

  modport slave (
    input  count, clr_err,
    output wrap_tick, wrap_cnt, restart, err, err_cnt, locked
  );

endinterface

// File: rtl/modn_next.sv
// Sequence arithmetic for a mod-N count: classifies the step from prev to count.
module modn_next
  import modn_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] prev,
  input  logic [WIDTH-1:0] count,
  output logic             is_last,
  output logic             step_ok,
  output logic             is_restart,
  output logic             in_range
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(N - 1);

  logic [WIDTH-1:0] expected;

  assign is_last    = (prev == LAST);
  assign expected   = is_last ? '0 : prev + WIDTH'(1);
  assign step_ok    = (count == expected);
  // A zero that is not the legal successor means upstream was reset.
  assign is_restart = (count == '0) && !is_last;
  // Compare at 32 bits so N == 2**WIDTH does not truncate to zero.
  assign in_range   = (32'(count) < N);

endmodule

// File: rtl/modn_count_monitor.sv
// Checks that a sampled count follows the mod-N sequence; counts rollovers and illegal steps.
module modn_count_monitor
  import modn_pkg::*;
#(
  parameter int N      = DEF_N,
  parameter int WIDTH  = DEF_WIDTH,
  parameter int WRAP_W = DEF_WRAP_W,
  parameter int ERR_W  = DEF_ERR_W
) (
  input  logic                 clk,
  input  logic                 reset,
  modn_count_monitor_if.slave  bus
);

  state_t            state, state_n;
  logic [WIDTH-1:0]  prev;
  logic [WRAP_W-1:0] wrap_cnt;
  logic [ERR_W-1:0]  err_cnt;
  logic              wrap_tick, restart, err;

  logic wrap_tick_n, restart_n, err_n, wrap_inc, err_inc;
  logic is_last, step_ok, is_restart, in_range;

  modn_next #(.N(N), .WIDTH(WIDTH)) u_next (
    .prev       (prev),
    .count      (bus.count),
    .is_last    (is_last),
    .step_ok    (step_ok),
    .is_restart (is_restart),
    .in_range   (in_range)
  );

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
    state_n     = state;
    wrap_tick_n = 1'b0;
    restart_n   = 1'b0;
    err_n       = err & ~bus.clr_err;
    wrap_inc    = 1'b0;
    err_inc     = 1'b0;

    case (state)
      SYNC: begin
        if (in_range) begin
          state_n = TRACK;
        end else begin
          err_n   = 1'b1;
          err_inc = 1'b1;
          state_n = FAULT;
        end
      end
      TRACK: begin
        if (step_ok) begin
          wrap_tick_n = is_last;
          wrap_inc    = is_last;
        end else if (is_restart) begin
          restart_n = 1'b1;
        end else begin
          err_n   = 1'b1;
          err_inc = 1'b1;
          state_n = FAULT;
        end
      end
      FAULT: begin
        // err is already high here, so the default keeps it unless clr_err drops it.
        if (bus.clr_err) state_n = SYNC;
      end
      default: state_n = SYNC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= SYNC;
      prev      <= '0;
      wrap_tick <= 1'b0;
      restart   <= 1'b0;
      err       <= 1'b0;
      wrap_cnt  <= '0;
      err_cnt   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values, independent of statement order.
      state     <= state_n;
      prev      <= bus.count;
      wrap_tick <= wrap_tick_n;
      restart   <= restart_n;
      err       <= err_n;
      if (wrap_inc) wrap_cnt <= wrap_cnt + WRAP_W'(1);
      if (err_inc && !(&err_cnt)) err_cnt <= err_cnt + ERR_W'(1);
    end
  end

  assign bus.wrap_tick = wrap_tick;
  assign bus.wrap_cnt  = wrap_cnt;
  assign bus.restart   = restart;
  assign bus.err       = err;
  assign bus.err_cnt   = err_cnt;
  assign bus.locked    = (state == TRACK);

endmodule

// File: tb/tb_modn_count_monitor.sv
// Self-checking bench for modn_count_monitor: hand vectors, directed corner sequences, random vs a rule model.
module tb_modn_count_monitor;

  localparam int N      = 10;
  localparam int WIDTH  = 4;
  localparam int WRAP_W = 8;
  localparam int ERR_W  = 4;
  localparam int ERR_MAX = (1 << ERR_W) - 1;

  logic clk = 1'b0;
  logic reset = 1'b0;

  modn_count_monitor_if #(.WIDTH(WIDTH), .WRAP_W(WRAP_W), .ERR_W(ERR_W)) bus ();

  modn_count_monitor #(.N(N), .WIDTH(WIDTH), .WRAP_W(WRAP_W), .ERR_W(ERR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Rule model: what the monitor should report, from the sequence rules alone.
  int m_prev;
  bit m_synced, m_faulted;
  bit e_tick, e_restart, e_err;
  int e_ecnt, e_wcnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d, want %0d", name, $time, act, exp);
    end
  endtask

  task automatic flag_error();
    e_err     = 1'b1;
    e_ecnt    = (e_ecnt < ERR_MAX) ? e_ecnt + 1 : ERR_MAX;
    m_synced  = 1'b0;
    m_faulted = 1'b1;
  endtask

  task automatic model(input logic r, input int c, input logic clr);
    e_tick    = 1'b0;
    e_restart = 1'b0;
    if (!r) begin
      m_prev = 0; m_synced = 1'b0; m_faulted = 1'b0;
      e_err = 1'b0; e_ecnt = 0; e_wcnt = 0;
    end else begin
      if (clr) e_err = 1'b0;
      if (m_faulted) begin
        if (clr) m_faulted = 1'b0;
      end else if (!m_synced) begin
        if (c < N) m_synced = 1'b1;
        else flag_error();
      end else if (c == (m_prev + 1) % N) begin
        if (c == 0) begin
          e_tick = 1'b1;
          e_wcnt = (e_wcnt + 1) % (1 << WRAP_W);
        end
      end else if (c == 0) begin
        e_restart = 1'b1;
      end else begin
        flag_error();
      end
      m_prev = c;
    end
  endtask

  task automatic compare_model();
    check("wrap_tick", bus.wrap_tick, e_tick);
    check("restart",   bus.restart,   e_restart);
    check("err",       bus.err,       e_err);
    check("err_cnt",   bus.err_cnt,   e_ecnt);
    check("wrap_cnt",  bus.wrap_cnt,  e_wcnt);
    check("locked",    bus.locked,    m_synced);
  endtask

  // One clock: drive inputs, let the edge happen, update the model, compare 1 time unit later.
  task automatic cycle(input logic r, input int c, input logic clr);
    reset       = r;
    bus.count   = WIDTH'(c);
    bus.clr_err = clr;
    @(posedge clk);
    model(r, c, clr);
    #1;
    compare_model();
  endtask

  typedef struct {
    logic r;
    int   c;
    logic clr;
    logic tick;
    logic rs;
    logic err;
    int   ecnt;
    logic lock;
    int   wcnt;
  } vec_t;

  localparam int NV = 29;
  vec_t tbl [NV];

  int ticks;
  int cur;

  initial begin
    bus.count   = '0;
    bus.clr_err = 1'b0;

    //            r  c  clr   tick rs err ecnt lock wcnt
    tbl[0]  = '{1'b0,  0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0};
    tbl[1]  = '{1'b0,  0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0};
    tbl[2]  = '{1'b1,  5, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1, 0};
    tbl[3]  = '{1'b1,  6, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1, 0};
    tbl[4]  = '{1'b1,  0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b1, 0};
    tbl[5]  = '{1'b1,  1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1, 0};
    tbl[6]  = '{1'b1,  2, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1, 0};
    tbl[7]  = '{1'b1,  3, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1, 0};
    tbl[8]  = '{1'b1,  4, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1, 0};
    tbl[9]  = '{1'b1,  4, 1'b0, 1'b0, 1'b0, 1'b1, 1, 1'b0, 0};
    tbl[10] = '{1'b1,  5, 1'b0, 1'b0, 1'b0, 1'b1, 1, 1'b0, 0};
    tbl[11] = '{1'b1,  6, 1'b1, 1'b0, 1'b0, 1'b0, 1, 1'b0, 0};
    tbl[12] = '{1'b1,  7, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b1, 0};
    tbl[13] = '{1'b1,  8, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b1, 0};
    tbl[14] = '{1'b1,  9, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b1, 0};
    tbl[15] = '{1'b1,  0, 1'b0, 1'b1, 1'b0, 1'b0, 1, 1'b1, 1};
    tbl[16] = '{1'b1,  1, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b1, 1};
    tbl[17] = '{1'b1, 12, 1'b0, 1'b0, 1'b0, 1'b1, 2, 1'b0, 1};
    tbl[18] = '{1'b1, 13, 1'b0, 1'b0, 1'b0, 1'b1, 2, 1'b0, 1};
    tbl[19] = '{1'b1,  3, 1'b0, 1'b0, 1'b0, 1'b1, 2, 1'b0, 1};
    tbl[20] = '{1'b1,  0, 1'b1, 1'b0, 1'b0, 1'b0, 2, 1'b0, 1};
    tbl[21] = '{1'b1, 14, 1'b0, 1'b0, 1'b0, 1'b1, 3, 1'b0, 1};
    tbl[22] = '{1'b1,  0, 1'b1, 1'b0, 1'b0, 1'b0, 3, 1'b0, 1};
    tbl[23] = '{1'b1,  1, 1'b0, 1'b0, 1'b0, 1'b0, 3, 1'b1, 1};
    tbl[24] = '{1'b1,  3, 1'b1, 1'b0, 1'b0, 1'b1, 4, 1'b0, 1};
    tbl[25] = '{1'b1,  4, 1'b1, 1'b0, 1'b0, 1'b0, 4, 1'b0, 1};
    tbl[26] = '{1'b1,  9, 1'b0, 1'b0, 1'b0, 1'b0, 4, 1'b1, 1};
    tbl[27] = '{1'b1,  0, 1'b1, 1'b1, 1'b0, 1'b0, 4, 1'b1, 2};
    tbl[28] = '{1'b1,  9, 1'b0, 1'b0, 1'b0, 1'b1, 5, 1'b0, 2};

    for (int i = 0; i < NV; i++) begin
      cycle(tbl[i].r, tbl[i].c, tbl[i].clr);
      check($sformatf("vec%0d.wrap_tick", i), bus.wrap_tick, tbl[i].tick);
      check($sformatf("vec%0d.restart", i),   bus.restart,   tbl[i].rs);
      check($sformatf("vec%0d.err", i),       bus.err,       tbl[i].err);
      check($sformatf("vec%0d.err_cnt", i),   bus.err_cnt,   tbl[i].ecnt);
      check($sformatf("vec%0d.locked", i),    bus.locked,    tbl[i].lock);
      check($sformatf("vec%0d.wrap_cnt", i),  bus.wrap_cnt,  tbl[i].wcnt);
    end

    // Reset 2 cycles, then 0..9 repeating for 25 cycles.
    cycle(1'b0, 0, 1'b0);
    cycle(1'b0, 0, 1'b0);
    ticks = 0;
    for (int i = 0; i < 25; i++) begin
      cycle(1'b1, i % N, 1'b0);
      if (i == 0) check("lockin.locked", bus.locked, 1);
      if (bus.wrap_tick) ticks++;
    end
    check("count25.ticks", ticks, 2);
    check("count25.wrap_cnt", bus.wrap_cnt, 2);
    check("count25.err", bus.err, 0);

    // Randomised mostly-legal traffic with restarts, glitches, clears and resets.
    cur = 0;
    for (int i = 0; i < 400; i++) begin
      int p;
      logic r, clr;
      p   = $urandom_range(99);
      r   = ($urandom_range(99) >= 2);
      clr = ($urandom_range(99) < 10);
      if (p < 85)      cur = (cur + 1) % N;
      else if (p < 90) cur = 0;
      else             cur = $urandom_range(15);
      cycle(r, cur, clr);
    end

    // err_cnt saturation over 20 fault/clear rounds.
    cycle(1'b0, 0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 15, 1'b0);
      cycle(1'b1, 0, 1'b1);
    end
    check("sat.err_cnt", bus.err_cnt, ERR_MAX);

    // 256 rollovers bring wrap_cnt back to 0 without an error.
    cycle(1'b0, 0, 1'b0);
    ticks = 0;
    for (int i = 0; i <= 256 * N; i++) begin
      cycle(1'b1, i % N, 1'b0);
      if (bus.wrap_tick) ticks++;
    end
    check("wrap256.ticks", ticks, 256);
    check("wrap256.wrap_cnt", bus.wrap_cnt, 0);
    check("wrap256.err", bus.err, 0);

    // Mid-operation reset with wrap_cnt=3 and err=1.
    cycle(1'b0, 0, 1'b0);
    for (int i = 0; i <= 3 * N; i++) cycle(1'b1, i % N, 1'b0);
    cycle(1'b1, 5, 1'b0);
    check("midrst.pre_wrap_cnt", bus.wrap_cnt, 3);
    check("midrst.pre_err", bus.err, 1);
    cycle(1'b0, 6, 1'b0);
    check("midrst.wrap_cnt", bus.wrap_cnt, 0);
    check("midrst.err", bus.err, 0);
    check("midrst.err_cnt", bus.err_cnt, 0);
    check("midrst.locked", bus.locked, 0);
    cycle(1'b1, 0, 1'b0);
    cycle(1'b1, 1, 1'b0);
    cycle(1'b1, 2, 1'b0);

    // A reset pulse that begins and ends between edges must be ignored.
    reset = 1'b0;
    #2;
    reset = 1'b1;
    cycle(1'b1, 3, 1'b0);
    check("glitch.locked", bus.locked, 1);
    cycle(1'b1, 4, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
